// File: rtl/mem_port_arbiter_if.sv
// Bundle between the cache/store-buffer front end, the memory port and the arbiter.
// Latency: none. This file only groups signals.
// Backpressure: mem_ready is the only stall. Requesters hold their level requests until they receive a pulse.
// Ports:
//   requesters  imiss_req/addr, dmiss_req/addr, sb_req/addr/data -> arbiter
//   pulses      ifill, dfill, sb_ack, fill_data, busy            <- arbiter
//   memory      mem_req/we/addr/wdata <- arbiter, mem_ready/rdata -> arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
);
  logic              imiss_req;
  logic [ADDR_W-1:0] imiss_addr;
  logic              dmiss_req;
  logic [ADDR_W-1:0] dmiss_addr;
  logic              sb_req;
  logic [ADDR_W-1:0] sb_addr;
  logic [DATA_W-1:0] sb_data;
  logic              ifill;
  logic              dfill;
  logic              sb_ack;
  logic [LINE_W-1:0] fill_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;
  logic              busy;

  // Arbiter side.
  modport master (
    input  imiss_req, imiss_addr, dmiss_req, dmiss_addr, sb_req, sb_addr, sb_data,
    input  mem_ready, mem_rdata,
    output ifill, dfill, sb_ack, fill_data, busy,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Front end and memory model side.
  modport slave (
    output imiss_req, imiss_addr, dmiss_req, dmiss_addr, sb_req, sb_addr, sb_data,
    output mem_ready, mem_rdata,
    input  ifill, dfill, sb_ack, fill_data, busy,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among I-fill, D-fill and store drain. Priority is D > I > SB.
// Store drains are forced through after STARVE_MAX lost grants.
// Latency: the pulse comes in the RESP cycle, which follows the cycle with mem_ready.
// That is at least 2 edges after the request is sampled. Throughput is at most one transaction per 3 cycles.
// Backpressure: the arbiter holds mem_req with a stable address and data until mem_ready.
// Requests that arrive while busy wait in IDLE; there is no preemption.
// Ports: clk, rst_n (async, active low), and bus (mem_port_arbiter_if.master).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_W     = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {ID_D, ID_I, ID_SB} id_t;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  state_t            state;
  id_t               cur_id;
  logic [3:0]        starve_cnt;
  logic              mem_req_q, mem_we_q, busy_q;
  logic              ifill_q, dfill_q, sb_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] fill_data_q;

  logic              grant_vld;
  id_t               grant_id;

  // Arbitration is only acted on in IDLE. The starved store drain beats both fills.
  always_comb begin
    grant_vld = bus.dmiss_req | bus.imiss_req | bus.sb_req;
    grant_id  = ID_SB;
    if (bus.sb_req && (starve_cnt == CNT_MAX)) grant_id = ID_SB;
    else if (bus.dmiss_req)                    grant_id = ID_D;
    else if (bus.imiss_req)                    grant_id = ID_I;
    else                                       grant_id = ID_SB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_id      <= ID_D;
      starve_cnt  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      ifill_q     <= 1'b0;
      dfill_q     <= 1'b0;
      sb_ack_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_data_q <= '0;
    end else begin
      // The pulses are high only in the RESP cycle.
      ifill_q  <= 1'b0;
      dfill_q  <= 1'b0;
      sb_ack_q <= 1'b0;

      // The counter tracks consecutive fill grants taken while a store waits.
      // It clears whenever the store buffer empties, in any state.
      if (state == IDLE && grant_vld && grant_id == ID_SB)
        starve_cnt <= '0;
      else if (!bus.sb_req)
        starve_cnt <= '0;
      else if (state == IDLE && grant_vld && starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (grant_vld) begin
            cur_id    <= grant_id;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ACCESS;
            case (grant_id)
              ID_D: begin
                mem_addr_q <= bus.dmiss_addr;
                mem_we_q   <= 1'b0;
              end
              ID_I: begin
                mem_addr_q <= bus.imiss_addr;
                mem_we_q   <= 1'b0;
              end
              default: begin
                mem_addr_q  <= bus.sb_addr;
                mem_wdata_q <= bus.sb_data;
                mem_we_q    <= 1'b1;
              end
            endcase
          end
        end
        ACCESS: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) fill_data_q <= bus.mem_rdata;
            dfill_q  <= (cur_id == ID_D);
            ifill_q  <= (cur_id == ID_I);
            sb_ack_q <= (cur_id == ID_SB);
            state    <= RESP;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ifill     = ifill_q;
  assign bus.dfill     = dfill_q;
  assign bus.sb_ack    = sb_ack_q;
  assign bus.fill_data = fill_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, built with STARVE_MAX=2.
// Latency: inputs are driven and outputs sampled on the falling edge.
// Backpressure: the bench acts as the memory and drives mem_ready per vector.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LINE_W(128)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LINE_W(128), .STARVE_MAX(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // The memory answers after `waits` stall cycles. On return the bench is in RESP.
  task automatic serve(input int waits, input logic [127:0] rd);
    for (int i = 0; i < waits; i++) begin
      bus.mem_ready = 1'b0;
      step();
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    step();
    bus.mem_ready = 1'b0;
  endtask

  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] R_I  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] R_D2 = 128'hFEED_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [127:0] JUNK = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
  localparam logic [127:0] R_5  = 128'h5555_0000_0000_0000_0000_0000_0000_0005;

  logic [1:0] seq_sb [6];
  logic [3:0] seq_cnt[6];

  initial begin
    rst_n = 1'b0;
    bus.imiss_req = 0; bus.imiss_addr = '0;
    bus.dmiss_req = 0; bus.dmiss_addr = '0;
    bus.sb_req = 0; bus.sb_addr = '0; bus.sb_data = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    step(); step();

    // Reset state
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pulses", {bus.ifill, bus.dfill, bus.sb_ack}, 0);
    check("rst_fill_data", bus.fill_data, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_starve", dut.starve_cnt, 0);
    rst_n = 1'b1;
    step();

    // D fill with 3 ACCESS cycles
    bus.dmiss_req = 1; bus.dmiss_addr = 32'h100;
    step();
    check("t1_busy", bus.busy, 1);
    check("t1_we", bus.mem_we, 0);
    check("t1_addr", bus.mem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      check("t1_mem_req_hi", bus.mem_req, 1);
      check("t1_no_pulse", bus.dfill, 0);
      if (i == 2) begin bus.mem_ready = 1; bus.mem_rdata = A5; end
      step();
    end
    bus.mem_ready = 0;
    check("t1_mem_req_lo", bus.mem_req, 0);
    check("t1_dfill", bus.dfill, 1);
    check("t1_fill_data", bus.fill_data, A5);
    bus.dmiss_req = 0;
    step();
    check("t1_dfill_1cyc", bus.dfill, 0);
    check("t1_busy_lo", bus.busy, 0);

    // All three requests together: grants go D, I, SB, with pulses 3 cycles apart
    bus.dmiss_req = 1; bus.dmiss_addr = 32'h200;
    bus.imiss_req = 1; bus.imiss_addr = 32'h300;
    bus.sb_req = 1; bus.sb_addr = 32'h400; bus.sb_data = 32'hDEADBEEF;
    step();
    check("t2_d_addr", bus.mem_addr, 32'h200);
    check("t2_d_we", bus.mem_we, 0);
    serve(0, R_D2);
    check("t2_d_pulses", {bus.dfill, bus.ifill, bus.sb_ack}, 3'b100);
    check("t2_d_fill", bus.fill_data, R_D2);
    bus.dmiss_req = 0;
    step();
    check("t2_idle1", bus.busy, 0);
    step();
    check("t2_i_addr", bus.mem_addr, 32'h300);
    serve(0, R_I);
    check("t2_i_pulses", {bus.dfill, bus.ifill, bus.sb_ack}, 3'b010);
    check("t2_i_fill", bus.fill_data, R_I);
    bus.imiss_req = 0;
    step();
    step();
    check("t2_sb_addr", bus.mem_addr, 32'h400);
    check("t2_sb_we", bus.mem_we, 1);
    check("t2_sb_wdata", bus.mem_wdata, 32'hDEADBEEF);
    serve(0, JUNK);
    check("t2_sb_pulses", {bus.dfill, bus.ifill, bus.sb_ack}, 3'b001);
    check("t2_sb_fill_keep", bus.fill_data, R_I);
    bus.sb_req = 0;
    step();
    check("t2_end_busy", bus.busy, 0);

    // Starvation with STARVE_MAX=2: grants go D, D, SB, D, D, SB
    seq_sb  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    seq_cnt = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
    bus.dmiss_req = 1; bus.dmiss_addr = 32'h500;
    bus.sb_req = 1; bus.sb_addr = 32'h600; bus.sb_data = 32'hCAFE0001;
    for (int g = 0; g < 6; g++) begin
      step();
      check($sformatf("t3_we_g%0d", g), bus.mem_we, seq_sb[g][0]);
      check($sformatf("t3_cnt_g%0d", g), dut.starve_cnt, seq_cnt[g]);
      serve(0, R_D2);
      check($sformatf("t3_pulse_g%0d", g), {bus.dfill, bus.sb_ack},
            seq_sb[g][0] ? 2'b01 : 2'b10);
      step();
    end
    bus.dmiss_req = 0; bus.sb_req = 0;
    step();
    check("t3_end_busy", bus.busy, 0);

    // Reset during the ACCESS of an I fill
    bus.imiss_req = 1; bus.imiss_addr = 32'h700;
    step();
    check("t4_mem_req_pre", bus.mem_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t4_mem_req_async", bus.mem_req, 0);
    check("t4_busy_async", bus.busy, 0);
    step();
    check("t4_no_ifill", bus.ifill, 0);
    #1 rst_n = 1'b1;
    step();
    check("t4_regrant_req", bus.mem_req, 1);
    check("t4_regrant_addr", bus.mem_addr, 32'h700);
    serve(1, R_I);
    check("t4_ifill", bus.ifill, 1);
    bus.imiss_req = 0;
    step();

    // The request drops and the address changes during ACCESS
    bus.imiss_req = 1; bus.imiss_addr = 32'h800;
    step();
    bus.imiss_req = 0; bus.imiss_addr = 32'h900;
    bus.mem_ready = 0;
    step();
    check("t5_addr_held", bus.mem_addr, 32'h800);
    serve(0, R_5);
    check("t5_ifill", bus.ifill, 1);
    check("t5_fill", bus.fill_data, R_5);
    step();
    step();
    check("t5_no_regrant", bus.mem_req, 0);
    check("t5_busy", bus.busy, 0);

    // Store alone with mem_ready in the first ACCESS cycle
    bus.sb_req = 1; bus.sb_addr = 32'hA00; bus.sb_data = 32'h12345678;
    step();
    check("t6_no_early_ack", bus.sb_ack, 0);
    check("t6_wdata", bus.mem_wdata, 32'h12345678);
    serve(0, JUNK);
    check("t6_sb_ack", bus.sb_ack, 1);
    check("t6_fill_keep", bus.fill_data, R_5);
    bus.sb_req = 0;
    step();
    check("t6_ack_1cyc", bus.sb_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
